// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-port arbiter merging pipeline write-backs with a FIFO of late results
module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p_we,
  input  logic [ADDR_W-1:0]       p_waddr,
  input  logic [DATA_W-1:0]       p_wdata,
  input  logic                    l_valid,
  output logic                    l_ready,
  input  logic [ADDR_W-1:0]       l_waddr,
  input  logic [DATA_W-1:0]       l_wdata,
  output logic                    rf_we,
  output logic [ADDR_W-1:0]       rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic [(1<<ADDR_W)-1:0]  pending,
  output logic                    stall_req,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_live;
  logic [PW:0]       r_wr, r_rd;
  logic [PW:0]       w_count;
  logic [PW-1:0]     w_head, w_tail;
  logic              w_full, w_pw, w_push, w_pop;
  assign w_count    = r_wr - r_rd;
  assign w_head     = r_rd[PW-1:0];
  assign w_tail     = r_wr[PW-1:0];
  assign w_full     = w_count == FULL;
  assign w_pw       = p_we && p_waddr != '0;
  assign w_push     = l_valid && l_ready && l_waddr != '0;
  assign w_pop      = !w_pw && w_count != '0;
  assign l_ready    = !rst && !w_full;
  assign stall_req  = w_full;
  assign fifo_count = w_count;
  // live bits are cleared on pop, so only occupied entries can be live
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_live[i]) pending[r_addr[i]] = 1'b1;
    pending[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_pw && r_addr[i] == p_waddr) r_live[i] <= 1'b0;
      if (w_pop) begin
        r_live[w_head] <= 1'b0;
        r_rd           <= r_rd + 1'b1;
      end
      if (w_push) begin
        r_addr[w_tail] <= l_waddr;
        r_data[w_tail] <= l_wdata;
        r_live[w_tail] <= !(w_pw && p_waddr == l_waddr);
        r_wr           <= r_wr + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (w_pw) begin
      rf_we    <= 1'b1;
      rf_waddr <= p_waddr;
      rf_wdata <= p_wdata;
    end else if (w_pop) begin
      rf_we <= r_live[w_head];
      if (r_live[w_head]) begin
        rf_waddr <= r_addr[w_head];
        rf_wdata <= r_data[w_head];
      end
    end else begin
      rf_we <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus checked every cycle against a queue-based model of the arbiter
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1;
  logic p_we = 0, l_valid = 0;
  logic [4:0] p_waddr = 0, l_waddr = 0;
  logic [31:0] p_wdata = 0, l_wdata = 0;
  logic l_ready, rf_we, stall_req;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata, pending;
  logic [2:0] fifo_count;
  int checks = 0, failures = 0;
  typedef struct {logic [4:0] a; logic [31:0] d; bit live;} ent_t;
  ent_t q[$];
  logic m_we = 0;
  logic [4:0] m_wa = 0;
  logic [31:0] m_wd = 0;
  logic [31:0] tb_rf [32];

  wb_arbiter #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata),
    .l_valid(l_valid), .l_ready(l_ready), .l_waddr(l_waddr), .l_wdata(l_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending(pending), .stall_req(stall_req), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, req, $time);
    end
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] p = 0;
    foreach (q[i]) if (q[i].live) p[q[i].a] = 1'b1;
    return p;
  endfunction

  // Model of one clock edge, from the inputs held across it
  task automatic model_edge();
    bit pw, acc;
    ent_t h;
    if (rst) begin
      q.delete();
      m_we = 0; m_wa = 0; m_wd = 0;
      return;
    end
    pw  = p_we && p_waddr != 0;
    acc = l_valid && q.size() < DEPTH && l_waddr != 0;
    if (pw) begin
      foreach (q[i]) if (q[i].a == p_waddr) q[i].live = 0;
      m_we = 1; m_wa = p_waddr; m_wd = p_wdata;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      m_we = h.live;
      if (h.live) begin m_wa = h.a; m_wd = h.d; end
    end else m_we = 0;
    if (acc) q.push_back('{l_waddr, l_wdata, !(pw && p_waddr == l_waddr)});
  endtask

  task automatic compare();
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_waddr", 64'(rf_waddr), 64'(m_wa));
    chk("rf_wdata", 64'(rf_wdata), 64'(m_wd));
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("pending", 64'(pending), 64'(m_pending()));
    chk("stall_req", 64'(stall_req), 64'(q.size() == DEPTH));
    chk("l_ready", 64'(l_ready), 64'(!rst && q.size() < DEPTH));
  endtask

  task automatic cyc();
    logic we_s, rst_s;
    logic [4:0] a_s;
    logic [31:0] d_s;
    we_s = rf_we; a_s = rf_waddr; d_s = rf_wdata; rst_s = rst;
    @(posedge clk);
    if (we_s && !rst_s) tb_rf[a_s] = d_s;
    model_edge();
    #1 compare();
  endtask

  task automatic pw(logic we, logic [4:0] a, logic [31:0] d);
    p_we = we; p_waddr = a; p_wdata = d;
  endtask

  task automatic lw(logic v, logic [4:0] a, logic [31:0] d);
    l_valid = v; l_waddr = a; l_wdata = d;
  endtask

  initial begin
    foreach (tb_rf[i]) tb_rf[i] = 0;
    cyc(); cyc();
    chk("rst_rf_we", 64'(rf_we), 0);
    chk("rst_count", 64'(fifo_count), 0);
    chk("rst_l_ready", 64'(l_ready), 0);
    rst = 0;
    #1 chk("l_ready_after_rst", 64'(l_ready), 1);
    cyc();
    // pipeline write latency
    pw(1, 3, 32'hA5A5_0001); cyc(); pw(0, 0, 0);
    chk("p_we", 64'(rf_we), 1);
    chk("p_waddr", 64'(rf_waddr), 3);
    chk("p_wdata", 64'(rf_wdata), 64'h A5A5_0001);
    cyc();
    chk("p_idle", 64'(rf_we), 0);
    // late write minimum latency
    lw(1, 5, 32'h1234); cyc(); lw(0, 0, 0);
    chk("late_pend", 64'(pending[5]), 1);
    chk("late_cnt1", 64'(fifo_count), 1);
    cyc();
    chk("late_we", 64'(rf_we), 1);
    chk("late_wa", 64'(rf_waddr), 5);
    chk("late_wd", 64'(rf_wdata), 64'h1234);
    chk("late_pend0", 64'(pending[5]), 0);
    chk("late_cnt0", 64'(fifo_count), 0);
    // late result starved by continuous pipeline writes
    pw(1, 2, 32'h22); lw(1, 7, 32'h11); cyc(); lw(0, 0, 0);
    for (int i = 0; i < 3; i++) cyc();
    chk("held_pend", 64'(pending[7]), 1);
    chk("held_wa", 64'(rf_waddr), 2);
    pw(0, 0, 0); cyc();
    chk("held_drain_wa", 64'(rf_waddr), 7);
    chk("held_drain_wd", 64'(rf_wdata), 64'h11);
    // kill by younger pipeline write
    lw(1, 9, 32'hDEAD); cyc(); lw(0, 0, 0);
    chk("kill_pend1", 64'(pending[9]), 1);
    pw(1, 9, 32'hBEEF); cyc(); pw(0, 0, 0);
    chk("kill_wd", 64'(rf_wdata), 64'hBEEF);
    chk("kill_pend0", 64'(pending[9]), 0);
    chk("kill_cnt", 64'(fifo_count), 1);
    cyc();
    chk("kill_pop_we", 64'(rf_we), 0);
    chk("kill_pop_wd", 64'(rf_wdata), 64'hBEEF);
    cyc();
    chk("kill_rf9", 64'(tb_rf[9]), 64'hBEEF);
    // same-cycle push and pipeline write to the same register
    pw(1, 4, 32'h44); lw(1, 4, 32'h40); cyc(); pw(0, 0, 0); lw(0, 0, 0);
    chk("same_pend", 64'(pending[4]), 0);
    cyc();
    chk("same_pop_we", 64'(rf_we), 0);
    cyc();
    chk("same_rf4", 64'(tb_rf[4]), 64'h44);
    // fill, stall, bubble drain
    for (int k = 0; k < 4; k++) begin
      pw(1, 2, 32'(k)); lw(1, 5'(10 + k), 32'h100 + 32'(k)); cyc();
    end
    chk("full_cnt", 64'(fifo_count), 4);
    chk("full_ready", 64'(l_ready), 0);
    chk("full_stall", 64'(stall_req), 1);
    pw(0, 0, 0); lw(1, 14, 32'h55); cyc();
    chk("bubble_cnt", 64'(fifo_count), 3);
    chk("bubble_wa", 64'(rf_waddr), 10);
    chk("bubble_wd", 64'(rf_wdata), 64'h100);
    chk("bubble_ready", 64'(l_ready), 1);
    pw(1, 2, 32'h9); cyc(); lw(0, 0, 0);
    chk("refill_cnt", 64'(fifo_count), 4);
    pw(0, 0, 0);
    for (int i = 0; i < 6; i++) cyc();
    chk("drain_cnt", 64'(fifo_count), 0);
    chk("drain_rf13", 64'(tb_rf[13]), 64'h103);
    chk("drain_rf14", 64'(tb_rf[14]), 64'h55);
    // register 0 is never queued nor written
    pw(1, 0, 32'hEE); lw(1, 0, 32'hFF); cyc(); pw(0, 0, 0); lw(0, 0, 0);
    chk("r0_cnt", 64'(fifo_count), 0);
    chk("r0_we", 64'(rf_we), 0);
    chk("r0_pend", 64'(pending), 0);
    cyc();
    chk("r0_rf0", 64'(tb_rf[0]), 0);
    // reset with queued entries
    pw(1, 2, 32'h7);
    for (int k = 0; k < 3; k++) begin lw(1, 5'(20 + k), 32'h200 + 32'(k)); cyc(); end
    lw(0, 0, 0); pw(0, 0, 0);
    chk("pre_rst_cnt", 64'(fifo_count), 3);
    rst = 1; cyc(); rst = 0;
    chk("mid_rst_cnt", 64'(fifo_count), 0);
    chk("mid_rst_pend", 64'(pending), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_we", 64'(rf_we), 0);
    end
    chk("post_rst_rf20", 64'(tb_rf[20]), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that owns the single write port of the pipeline CPU's 32x32 register file. It merges two result sources: in-order pipeline write-backs, which always win and never stall, and out-of-order late results (cache-miss loads, multi-cycle mul/div), which are buffered in a small FIFO and drained into idle write slots. It also publishes a per-register pending mask so hazard logic can stall readers of registers with queued writes.

## Interface
- DEPTH, 4, late-result FIFO entries; power of 2, minimum 2
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- p_we  in  1  pipeline write-back valid; always accepted
- p_waddr  in  ADDR_W  pipeline destination register
- p_wdata  in  DATA_W  pipeline result
- l_valid  in  1  late result valid
- l_ready  out  1  late result accepted this cycle when l_valid && l_ready
- l_waddr  in  ADDR_W  late destination register
- l_wdata  in  DATA_W  late result
- rf_we  out  1  register-file write enable; registered
- rf_waddr  out  ADDR_W  register-file write address; registered
- rf_wdata  out  DATA_W  register-file write data; registered
- pending  out  2^ADDR_W  bit r is set while a live FIFO entry targets register r; bit 0 is always 0
- stall_req  out  1  asks the pipeline to insert a write-back bubble
- fifo_count  out  log2(DEPTH)+1  number of occupied FIFO entries, including killed ones

## Operation
- FIFO entry fields: waddr, wdata, live bit. Pointers are circular with log2(DEPTH)+1 bits; full when count == DEPTH, empty when count == 0.
- Push: on l_valid && l_ready. If l_waddr == 0, accept the request and discard it; no push.
- Output slot selection, evaluated every cycle in priority order:
  - p_we && p_waddr != 0: load rf_* with the pipeline write.
  - Otherwise, if the FIFO is non-empty: pop the head. If the head is live, load rf_* with rf_we=1. If it is killed, load rf_we=0 and keep rf_waddr/rf_wdata unchanged.
  - Otherwise: rf_we=0.
- p_we with p_waddr == 0 counts as an idle slot. It is not written and the FIFO may drain in that cycle.
- Ordering rule: a pipeline write is always younger than any queued late write to the same register.
  - On p_we && p_waddr != 0, clear the live bit of every FIFO entry whose waddr == p_waddr.
  - A late write pushed in the same cycle to the same address is enqueued already killed.
- Entries are never removed on kill. They drain in order and produce a no-write slot, so fifo_count is unchanged by kills.
- pending[r] is the OR over occupied entries of (live && waddr == r). It is combinational from registered FIFO state and does not include the rf_* output register.
- l_ready = !rst && (count < DEPTH), from registered count. No same-cycle push-while-full even when a pop occurs.
- stall_req = (count == DEPTH). The pipeline is required to hold p_we=0 in the following cycle, which guarantees one drain slot.
- The arbiter does no read bypass; the register file forwards rf_wdata itself during the write cycle.

## Timing
- Reset values (rst high at an edge):
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - count=0, pointers=0, all live bits 0
  - pending=0, stall_req=0, fifo_count=0
  - l_ready=0 while rst is high; l_ready=1 in the first cycle after rst falls
- Reset mid-operation: all queued entries are dropped with no register-file write. An rf_we already presented completes its register-file write only if rst is low on that edge.
- Pipeline write latency: inputs sampled at edge N appear on rf_* after edge N and are written to the register file at edge N+1.
- Late write, minimum latency:
  - Accepted at edge N, popped at edge N+1, written to the register file at edge N+2.
  - No direct input-to-output path.
- pending rises the cycle after the push edge. It falls the cycle after the pop or kill edge.
- Simultaneous push and pop with count < DEPTH: count unchanged, and both operations take effect.
- Continuous pipeline writes starve the FIFO only until it fills. stall_req then forces a drain bubble, so a late result waits at most DEPTH bubbles.

## Test plan
- Reset, then p_we=1, p_waddr=3, p_wdata=0xA5A5_0001 for one cycle -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0xA5A5_0001; following cycle rf_we=0.
- Pipeline idle, push late (5, 0x1234) at edge N -> pending[5]=1 after N; rf_we=1, waddr=5, wdata=0x1234 after edge N+1; pending[5]=0 and fifo_count=0 after N+1.
- Push late (7, 0x11) while p_we holds every cycle to reg 2 -> entry held, pending[7]=1; after p_we drops, rf_waddr=7, rf_wdata=0x11 one cycle later.
- Queue late (9, 0xDEAD), then pipeline write (9, 0xBEEF) before the drain -> rf_* shows (9, 0xBEEF); pending[9] clears; later pop gives rf_we=0; register 9 ends at 0xBEEF.
- Push four late writes with the pipeline writing every cycle -> fifo_count=4, l_ready=0, stall_req=1; a 5th l_valid is held; after one pipeline bubble, the head drains and l_ready returns to 1.
- Push late (0, 0xFF) and pipeline write (0, 0xEE) -> no FIFO push, rf_we stays 0, pending=0; rst asserted with 3 queued entries -> fifo_count=0, pending=0, no rf_we afterwards.
